sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Purpose: synchronises and debounces raw slide-switch inputs before they reach the priority encoder and the seven-segment display path.

Interface
REQ-001 Parameter WIDTH, default 8, number of independent switch bits.
REQ-002 Parameter N, default 4, consecutive stable cycles required before accepting a new level; legal range 2..65535.
REQ-003 clk  input  1  single clock; every register updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in  input  WIDTH  raw asynchronous switch levels.
REQ-006 out  output  WIDTH  debounced levels (registered).
REQ-007 rise  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change (registered).
REQ-008 fall  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change (registered).
REQ-009 changed  output  1  OR-reduction of rise|fall, registered in the same cycle as those pulses.

Function
REQ-010 Each bit SHALL pass through a 2-flop synchroniser, s1 then s2, before any comparison.
REQ-011 Each bit SHALL own an independent counter cnt[i] of width max(1, ceil(log2 N)).
REQ-012 Per bit, each cycle, with s2[i]==out[i]: cnt[i]<=0, out[i] holds.
REQ-013 Per bit, each cycle, with s2[i]!=out[i] and cnt[i]<N-1: cnt[i]<=cnt[i]+1, out[i] holds.
REQ-014 Per bit, each cycle, with s2[i]!=out[i] and cnt[i]==N-1: out[i]<=s2[i], cnt[i]<=0, and the matching rise[i] or fall[i] <=1.
REQ-015 rise, fall and changed SHALL be 0 in every cycle not covered by REQ-014; pulses last exactly one cycle.
REQ-016 Latency: after in[i] changes and then stays stable, out[i] SHALL change on exactly the (N+2)th rising edge that samples the new level; for N=4 this is the 6th edge.
REQ-017 Any excursion of s2[i] away from out[i] that lasts fewer than N consecutive cycles SHALL leave out[i] unchanged and produce no pulse; the counter restarts from 0 on return.
REQ-018 Bits SHALL be fully independent: simultaneous accepts on several bits SHALL assert all corresponding rise/fall bits in the same cycle, with changed=1 once.
REQ-019 The counter SHALL never exceed N-1 and SHALL never wrap.
REQ-020 The block SHALL contain no combinational path from in to any output.

Reset
REQ-021 While rst=1 at a rising edge: s1, s2, out, cnt, rise, fall and changed SHALL all become 0, regardless of in.
REQ-022 A reset asserted mid-count SHALL discard the partial count; after release, counting restarts from 0 with the full latency of REQ-016.
REQ-023 On the first cycle after rst deasserts, all outputs SHALL be 0.

Verification (WIDTH=8, N=4)
REQ-024 Reset: rst=1 for 2 cycles with in=8'hFF -> out=00, rise=fall=00, changed=0 throughout; after release, out=FF on the 6th edge, with rise=FF and changed=1 for one cycle.
REQ-025 Clean step: in 00->04, held -> out=04 after the 6th edge, rise=04 for one cycle, then rise=00; fall stays 00.
REQ-026 Glitch: in[0]=1 for 3 cycles, then 0 -> out stays 00; rise, fall and changed stay 0 throughout.
REQ-027 Bounce: in[3] toggles 1,0,1,1,0,1, then holds 1 -> exactly one rise=08 pulse, no fall pulse, final out=08.
REQ-028 Simultaneous: from out=01, in 01->80 in one step -> on the same cycle out=80, rise=80, fall=01, changed=1.
REQ-029 Reset mid-count: in 00->FF, rst=1 for 1 cycle at the 4th edge -> out stays 00 through reset; out=FF on the 6th edge after release.

Source files
------------

// File: rtl/sw_debounce_if.sv
// Switch-input bundle between the raw switch source and the debouncer.
interface sw_debounce_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (output in, input out, input rise, input fall, input changed);
    modport slave  (input in, output out, output rise, output fall, output changed);
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bit stability counter; a new level is
// accepted after N consecutive synchronised samples that differ from it.
module sw_debounce #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
) (
    input logic          clk,
    input logic          rst,
    sw_debounce_if.slave bus
);
    localparam int unsigned  CW      = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             changed_q;
    logic [WIDTH-1:0] accept;
    logic [CW-1:0]    cnt [WIDTH];

    // A bit is accepted when it has differed for the full N-sample window.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s2[i] != level[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            level     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= bus.in;
            s2 <= s1;
            for (int i = 0; i < WIDTH; i++) begin
                if ((s2[i] == level[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            level     <= level ^ accept;
            rise_q    <= accept & s2;
            fall_q    <= accept & ~s2;
            changed_q <= |accept;
        end
    end

    assign bus.out     = level;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.changed = changed_q;
endmodule

// File: tb/tb_sw_debounce.sv
// Randomised and directed bench for sw_debounce against a sliding-window model.
module tb_sw_debounce;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sw_debounce_if #(.WIDTH(WIDTH)) bus ();

    sw_debounce #(.WIDTH(WIDTH), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int chg_cnt  = 0;

    // Model: hist[j] is the input sampled j+1 edges ago; the compare at an
    // edge sees samples 2..N+1 edges old, i.e. hist[1..N].
    logic [WIDTH-1:0] hist [N+1];
    logic [WIDTH-1:0] m_out, m_rise, m_fall;
    logic             m_changed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [WIDTH-1:0] acc;
        if (rst) begin
            for (int j = 0; j <= N; j++) hist[j] = '0;
            m_out = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                acc[i] = 1'b1;
                for (int j = 1; j <= N; j++) begin
                    if (hist[j][i] == m_out[i]) acc[i] = 1'b0;
                end
            end
            m_rise    = acc & ~m_out;
            m_fall    = acc & m_out;
            m_changed = |acc;
            m_out     = m_out ^ acc;
            for (int j = N; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = bus.in;
        end
    endtask

    task automatic cycle(input logic [WIDTH-1:0] v, input logic r);
        bus.in = v;
        rst    = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("out",     32'(bus.out),     32'(m_out));
        check("rise",    32'(bus.rise),    32'(m_rise));
        check("fall",    32'(bus.fall),    32'(m_fall));
        check("changed", 32'(bus.changed), 32'(m_changed));
        if (bus.rise != '0) rise_cnt++;
        if (bus.fall != '0) fall_cnt++;
        if (bus.changed)    chg_cnt++;
    endtask

    task automatic cycles(input logic [WIDTH-1:0] v, input int n);
        for (int k = 0; k < n; k++) cycle(v, 1'b0);
    endtask

    task automatic clear_counts();
        rise_cnt = 0; fall_cnt = 0; chg_cnt = 0;
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        int               flip_div;

        // Reset with all switches high, then first acceptance on the 6th edge
        cycle(8'hFF, 1'b1);
        check("rst_out0", 32'(bus.out), 32'h00);
        cycle(8'hFF, 1'b1);
        check("rst_out1", 32'(bus.out), 32'h00);
        check("rst_chg",  32'(bus.changed), 32'h0);
        cycles(8'hFF, 5);
        check("rel_out5", 32'(bus.out), 32'h00);
        cycle(8'hFF, 1'b0);
        check("rel_out6",  32'(bus.out), 32'hFF);
        check("rel_rise6", 32'(bus.rise), 32'hFF);
        check("rel_chg6",  32'(bus.changed), 32'h1);
        cycle(8'hFF, 1'b0);
        check("rel_rise7", 32'(bus.rise), 32'h00);
        cycles(8'h00, 8);

        // Clean step
        clear_counts();
        cycles(8'h04, 5);
        check("step_out5", 32'(bus.out), 32'h00);
        cycle(8'h04, 1'b0);
        check("step_out6",  32'(bus.out), 32'h04);
        check("step_rise6", 32'(bus.rise), 32'h04);
        cycle(8'h04, 1'b0);
        check("step_rise7", 32'(bus.rise), 32'h00);
        check("step_fall",  32'(fall_cnt), 32'd0);
        cycles(8'h00, 8);

        // Short glitch
        clear_counts();
        cycles(8'h01, 3);
        cycles(8'h00, 10);
        check("glitch_out",  32'(bus.out), 32'h00);
        check("glitch_puls", 32'(rise_cnt + fall_cnt + chg_cnt), 32'd0);

        // Bounce then settle
        clear_counts();
        cycle(8'h08, 1'b0); cycle(8'h00, 1'b0); cycle(8'h08, 1'b0);
        cycle(8'h08, 1'b0); cycle(8'h00, 1'b0); cycle(8'h08, 1'b0);
        cycles(8'h08, 10);
        check("bounce_rise", 32'(rise_cnt), 32'd1);
        check("bounce_fall", 32'(fall_cnt), 32'd0);
        check("bounce_out",  32'(bus.out), 32'h08);

        // Simultaneous rise and fall
        cycles(8'h01, 10);
        check("sim_pre", 32'(bus.out), 32'h01);
        cycles(8'h80, 5);
        cycle(8'h80, 1'b0);
        check("sim_out",  32'(bus.out), 32'h80);
        check("sim_rise", 32'(bus.rise), 32'h80);
        check("sim_fall", 32'(bus.fall), 32'h01);
        check("sim_chg",  32'(bus.changed), 32'h1);
        cycles(8'h00, 10);

        // Reset mid-count discards the partial window
        cycles(8'hFF, 3);
        cycle(8'hFF, 1'b1);
        check("mid_rst_out", 32'(bus.out), 32'h00);
        cycles(8'hFF, 5);
        check("mid_out5", 32'(bus.out), 32'h00);
        cycle(8'hFF, 1'b0);
        check("mid_out6", 32'(bus.out), 32'hFF);

        // Random bouncing with varying bounce density and rare resets
        v = '0;
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 2))
                0:       flip_div = 2;
                1:       flip_div = 8;
                default: flip_div = 32;
            endcase
            for (int k = 0; k < 50; k++) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if ($urandom_range(0, flip_div - 1) == 0) v[i] = ~v[i];
                end
                cycle(v, ($urandom_range(0, 199) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
